// File: rtl/sdr_app_pkg.sv
// Shared SDRAM app-interface types: responder FSM states and
// the default widths used by both the responder and the generator.
package sdr_app_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_REF_LEAD = 2'd2,
    ST_REF_BUSY = 2'd3
  } sdr_state_t;

  localparam int SDR_ADDR_WIDTH = 21;
  localparam int SDR_DATA_WIDTH = 32;
  localparam int SDR_DM_WIDTH   = SDR_DATA_WIDTH / 8;

endpackage

// File: rtl/sdr_bram_dp.sv
// Simple dual-port byte-enable RAM: read-first, one-cycle
// registered read port that holds its value between reads.
module sdr_bram_dp #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int BW = DW / 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_be,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // no reset on the array: contents survive Rst
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      for (int i = 0; i < BW; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sdr_app_bram_responder.sv
// BRAM-backed SDRAM app responder with init/refresh emulation.
// Optional drop counter output Err_cnt under SDR_APP_RESP_ERR_EN.
module sdr_app_bram_responder
  import sdr_app_pkg::*;
#(
  parameter int ADDR_WIDTH  = SDR_ADDR_WIDTH,
  parameter int DATA_WIDTH  = SDR_DATA_WIDTH,
  parameter int DM_WIDTH    = SDR_DM_WIDTH,
  parameter int MEM_AW      = 12,
  parameter int RD_LATENCY  = 2,
  parameter int INIT_CYCLES = 64,
  parameter int REF_PERIOD  = 1024,
  parameter int REF_LEAD    = 4,
  parameter int REF_CYCLES  = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  output logic                  Sdr_init_done,
  output logic                  Sdr_init_ref_vld,
  input  logic                  App_wr_en,
  input  logic [ADDR_WIDTH-1:0] App_wr_addr,
  input  logic [DM_WIDTH-1:0]   App_wr_dm,
  input  logic [DATA_WIDTH-1:0] App_wr_din,
  input  logic                  App_rd_en,
  input  logic [ADDR_WIDTH-1:0] App_rd_addr,
  output logic                  Sdr_rd_en,
  output logic [DATA_WIDTH-1:0] Sdr_rd_dout
`ifdef SDR_APP_RESP_ERR_EN
  ,
  output logic [15:0]           Err_cnt
`endif
);

  localparam int IDLE_CYC = REF_PERIOD - REF_LEAD - REF_CYCLES;
  localparam int M1 = INIT_CYCLES > IDLE_CYC ? INIT_CYCLES : IDLE_CYC;
  localparam int M2 = REF_LEAD > REF_CYCLES ? REF_LEAD : REF_CYCLES;
  localparam int CMAX = M1 > M2 ? M1 : M2;
  localparam int CW = $clog2(CMAX + 1);

  sdr_state_t    state;
  logic [CW-1:0] cnt;
  logic          done_q;
  logic          refv_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= ST_INIT;
      cnt    <= '0;
      done_q <= 1'b0;
      refv_q <= 1'b1;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (cnt == CW'(INIT_CYCLES - 1)) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b1;
            refv_q <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_IDLE: begin
          if (cnt == CW'(IDLE_CYC - 1)) begin
            state  <= ST_REF_LEAD;
            cnt    <= '0;
            refv_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_REF_LEAD: begin
          if (cnt == CW'(REF_LEAD - 1)) begin
            state <= ST_REF_BUSY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_REF_BUSY: begin
          if (cnt == CW'(REF_CYCLES - 1)) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            refv_q <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign Sdr_init_done    = done_q;
  assign Sdr_init_ref_vld = refv_q;

  // REF_LEAD still services requests to cover the requester's stop lag
  logic accept;
  logic wr_acc;
  logic rd_acc;

  assign accept = (state == ST_IDLE) || (state == ST_REF_LEAD);
  assign wr_acc = App_wr_en && accept;
  assign rd_acc = App_rd_en && accept;

  logic unused_addr;
  assign unused_addr = ^{App_wr_addr[ADDR_WIDTH-1:MEM_AW],
                         App_rd_addr[ADDR_WIDTH-1:MEM_AW]};

  logic [DATA_WIDTH-1:0] ram_q;

  sdr_bram_dp #(
    .AW (MEM_AW),
    .DW (DATA_WIDTH),
    .BW (DM_WIDTH)
  ) u_ram (
    .Clk     (Clk),
    .Rst     (Rst),
    .wr_en   (wr_acc),
    .wr_addr (App_wr_addr[MEM_AW-1:0]),
    .wr_be   (~App_wr_dm),
    .wr_data (App_wr_din),
    .rd_en   (rd_acc),
    .rd_addr (App_rd_addr[MEM_AW-1:0]),
    .rd_data (ram_q)
  );

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      logic vld;
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) vld <= 1'b0;
        else     vld <= rd_acc;
      end
      assign Sdr_rd_en   = vld;
      assign Sdr_rd_dout = ram_q;
    end else begin : g_latn
      logic [RD_LATENCY-1:0] vld;
      logic [DATA_WIDTH-1:0] stg [RD_LATENCY-1];
      // each stage loads only with its valid so dout holds between reads
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          vld <= '0;
          for (int i = 0; i < RD_LATENCY - 1; i++) stg[i] <= '0;
        end else begin
          vld <= {vld[RD_LATENCY-2:0], rd_acc};
          if (vld[0]) stg[0] <= ram_q;
          for (int i = 1; i < RD_LATENCY - 1; i++) begin
            if (vld[i]) stg[i] <= stg[i-1];
          end
        end
      end
      assign Sdr_rd_en   = vld[RD_LATENCY-1];
      assign Sdr_rd_dout = stg[RD_LATENCY-2];
    end
  endgenerate

`ifdef SDR_APP_RESP_ERR_EN
  logic [1:0]  drops;
  logic [16:0] err_sum;
  logic [15:0] err_q;

  assign drops   = 2'(App_wr_en && !accept) + 2'(App_rd_en && !accept);
  assign err_sum = {1'b0, err_q} + 17'(drops);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err_q <= '0;
    end else if (drops != 2'd0) begin
      err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign Err_cnt = err_q;
`endif

endmodule

// File: tb/tb_sdr_app_bram_responder.sv
// Directed + random bench for sdr_app_bram_responder with a
// cycle-schedule/array reference model.
module tb_sdr_app_bram_responder;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int MAW = 12;
  localparam int DEPTH = 4096;
  localparam int LAT = 2;
  localparam int INIT = 16;
  localparam int P = 256;
  localparam int L = 4;
  localparam int C = 8;

  logic          Clk;
  logic          Rst;
  logic          Sdr_init_done;
  logic          Sdr_init_ref_vld;
  logic          App_wr_en;
  logic [AW-1:0] App_wr_addr;
  logic [3:0]    App_wr_dm;
  logic [DW-1:0] App_wr_din;
  logic          App_rd_en;
  logic [AW-1:0] App_rd_addr;
  logic          Sdr_rd_en;
  logic [DW-1:0] Sdr_rd_dout;
`ifdef SDR_APP_RESP_ERR_EN
  logic [15:0]   Err_cnt;
`endif

  sdr_app_bram_responder #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DM_WIDTH    (4),
    .MEM_AW      (MAW),
    .RD_LATENCY  (LAT),
    .INIT_CYCLES (INIT),
    .REF_PERIOD  (P),
    .REF_LEAD    (L),
    .REF_CYCLES  (C)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Sdr_init_done    (Sdr_init_done),
    .Sdr_init_ref_vld (Sdr_init_ref_vld),
    .App_wr_en        (App_wr_en),
    .App_wr_addr      (App_wr_addr),
    .App_wr_dm        (App_wr_dm),
    .App_wr_din       (App_wr_din),
    .App_rd_en        (App_rd_en),
    .App_rd_addr      (App_rd_addr),
    .Sdr_rd_en        (Sdr_rd_en),
    .Sdr_rd_dout      (Sdr_rd_dout)
`ifdef SDR_APP_RESP_ERR_EN
    ,
    .Err_cnt          (Err_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          checks;
  int          errors;
  int          t;
  int          m_err;
  logic [31:0] mdl [DEPTH];
  logic [3:0]  kn [DEPTH];
  int          q_due [$];
  logic [31:0] q_dat [$];
  logic [31:0] q_msk [$];
  logic [31:0] last_dat;
  logic [31:0] last_msk;

  // 0 init, 1 idle, 2 lead, 3 busy after n clock edges since release
  function automatic int ph(int n);
    int u;
    if (n < INIT) return 0;
    u = (n - INIT) % P;
    if (u < P - L - C) return 1;
    if (u < P - C) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] bmask(logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{b[i]}};
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    App_wr_en = 1'b0;
    App_rd_en = 1'b0;
    App_wr_addr = '0;
    App_rd_addr = '0;
    App_wr_dm = '0;
    App_wr_din = '0;
  endtask

  task automatic step();
    logic        acc;
    int          a;
    logic [31:0] wm;
    @(posedge Clk);
    t++;
    acc = (ph(t - 1) == 1) || (ph(t - 1) == 2);
    if (App_rd_en) begin
      if (acc) begin
        a = int'(App_rd_addr % DEPTH);
        q_due.push_back(t + LAT - 1);
        q_dat.push_back(mdl[a]);
        q_msk.push_back(bmask(kn[a]));
      end else if (m_err < 65535) m_err++;
    end
    if (App_wr_en) begin
      if (acc) begin
        a = int'(App_wr_addr % DEPTH);
        wm = bmask(~App_wr_dm);
        mdl[a] = (mdl[a] & ~wm) | (App_wr_din & wm);
        kn[a] = kn[a] | ~App_wr_dm;
      end else if (m_err < 65535) m_err++;
    end
    #1;
    chk("init_done", Sdr_init_done, ph(t) != 0);
    chk("ref_vld", Sdr_init_ref_vld, ph(t) != 1);
    if (q_due.size() > 0 && q_due[0] == t) begin
      void'(q_due.pop_front());
      last_dat = q_dat.pop_front();
      last_msk = q_msk.pop_front();
      chk("rd_en_hi", Sdr_rd_en, 1);
      chk("rd_dout", Sdr_rd_dout & last_msk, last_dat & last_msk);
    end else begin
      chk("rd_en_lo", Sdr_rd_en, 0);
      chk("rd_hold", Sdr_rd_dout & last_msk, last_dat & last_msk);
    end
`ifdef SDR_APP_RESP_ERR_EN
    chk("err_cnt", Err_cnt, m_err);
`endif
  endtask

  task automatic idle(int n);
    clr();
    repeat (n) step();
  endtask

  task automatic wr(int a, logic [31:0] d, logic [3:0] dm);
    clr();
    App_wr_en = 1'b1;
    App_wr_addr = AW'(a);
    App_wr_din = d;
    App_wr_dm = dm;
    step();
    clr();
  endtask

  task automatic rd(int a);
    clr();
    App_rd_en = 1'b1;
    App_rd_addr = AW'(a);
    step();
    clr();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_done", Sdr_init_done, 0);
    chk("rst_refv", Sdr_init_ref_vld, 1);
    chk("rst_rden", Sdr_rd_en, 0);
    chk("rst_dout", Sdr_rd_dout, 0);
`ifdef SDR_APP_RESP_ERR_EN
    chk("rst_err", Err_cnt, 0);
`endif
    Rst = 1'b0;
    t = 0;
    m_err = 0;
    q_due.delete();
    q_dat.delete();
    q_msk.delete();
    last_dat = '0;
    last_msk = '1;
  endtask

  initial begin
    int g;
`ifdef SDR_APP_RESP_ERR_EN
    logic [15:0] e0;
`endif
    checks = 0;
    errors = 0;
    Rst = 1'b1;
    clr();
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = '0;
      kn[i] = '0;
    end

    do_reset();
    idle(INIT + 4);

    wr(5, 32'hA5A5_0001, 4'b0000);
    rd(5);
    idle(1);
    chk("t2_rden", Sdr_rd_en, 1);
    chk("t2_dout", Sdr_rd_dout, 32'hA5A5_0001);
    idle(2);

    wr(7, 32'hFFFF_FFFF, 4'b0000);
    wr(7, 32'h1234_5678, 4'b0101);
    rd(7);
    idle(1);
    chk("t3_dout", Sdr_rd_dout, 32'h12FF_56FF);
    idle(2);

    wr(9, 32'h1, 4'b0000);
    clr();
    App_wr_en = 1'b1;
    App_wr_addr = AW'(9);
    App_wr_din = 32'h2;
    App_rd_en = 1'b1;
    App_rd_addr = AW'(9);
    step();
    rd(9);
    chk("t4_old", Sdr_rd_dout, 32'h1);
    idle(1);
    chk("t4_new", Sdr_rd_dout, 32'h2);
    idle(2);

    for (int i = 0; i < 64; i++) wr(i, $urandom, 4'b0000);
    for (int i = 0; i < 500; i++) begin
      App_wr_en = 1'($urandom_range(0, 1));
      App_rd_en = 1'($urandom_range(0, 1));
      App_wr_addr = AW'($urandom & 32'h1F_F03F);
      App_rd_addr = AW'($urandom & 32'h1F_F03F);
      if ($urandom_range(0, 3) == 0) App_rd_addr = App_wr_addr;
      App_wr_dm = 4'($urandom);
      App_wr_din = $urandom;
      step();
    end
    idle(4);

    g = 0;
    while (((t - INIT) % P) != P - L - C - 60 && g < 400) begin
      step();
      g++;
    end
    for (int i = 0; i < 40; i++) wr(1024 + i, 32'h0, 4'b0000);
`ifdef SDR_APP_RESP_ERR_EN
    e0 = Err_cnt;
`endif
    for (int i = 0; i < 40; i++) wr(1024 + i, 32'hB000_0000 + i, 4'b0000);
`ifdef SDR_APP_RESP_ERR_EN
    chk("t5_err8", Err_cnt - e0, 8);
`endif
    idle(2);
    for (int i = 0; i < 40; i++) rd(1024 + i);
    idle(3);
    rd(1024 + 22);
    idle(1);
    chk("t5_lead", Sdr_rd_dout, 32'hB000_0016);
    rd(1024 + 26);
    idle(1);
    chk("t5_busy", Sdr_rd_dout, 32'h0);
    idle(2);

    wr(32'h1000, 32'hC0DE_0042, 4'b0000);
    rd(0);
    idle(1);
    chk("t6_wrap", Sdr_rd_dout, 32'hC0DE_0042);
    rd(3);
    do_reset();
    idle(INIT + 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
